// File: rtl/serial_tx_queue.sv
// Byte FIFO feeding a serial transmitter through a send/acknowledge sequencer with retry on timeout.
// Optional saturating overflow counter on dropCount, built when SERIAL_TX_QUEUE_DROP_COUNT_EN is defined.
module serial_tx_queue #(
  parameter int DEPTH_LOG2  = 4,
  parameter int ACK_TIMEOUT = 255
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic [7:0]            wrData,
  input  logic                  wrEn,
  output logic                  full,
  output logic                  empty,
  output logic [DEPTH_LOG2:0]   count,
  output logic [7:0]            txData,
  output logic                  txSend,
  input  logic                  txReady,
  output logic                  busy,
  output logic [7:0]            dropCount
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0]   CNT_FULL = (DEPTH_LOG2 + 1)'(DEPTH);
  localparam logic [DEPTH_LOG2:0]   CNT_ONE  = (DEPTH_LOG2 + 1)'(1);
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = DEPTH_LOG2'(1);
  localparam logic [15:0]           TIMER_LOAD = 16'(ACK_TIMEOUT);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SEND,
    S_WAIT_BUSY,
    S_WAIT_DONE
  } state_t;

  logic [7:0]            mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
  logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
  logic [DEPTH_LOG2:0]   count_q, count_d;
  state_t                state_q, state_d;
  logic [15:0]           timer_q, timer_d;
  logic                  wr_fire;
  logic                  pop;

  assign full    = (count_q == CNT_FULL);
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign txData  = mem[rd_ptr_q];
  assign txSend  = (state_q == S_SEND);
  assign busy    = (state_q != S_IDLE);

  // full is the registered occupancy, so a pop in the same cycle cannot rescue a write
  assign wr_fire = wrEn & ~full;
  assign pop     = (state_q == S_WAIT_BUSY) & ~txReady;

  always_ff @(posedge CLK) begin
    if (wr_fire) begin
      mem[wr_ptr_q] <= wrData;
    end
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (wr_fire) begin
      wr_ptr_d = wr_ptr_q + PTR_ONE;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end
    if (wr_fire && !pop) begin
      count_d = count_q + CNT_ONE;
    end else if (!wr_fire && pop) begin
      count_d = count_q - CNT_ONE;
    end
  end

  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    case (state_q)
      S_IDLE: begin
        if (!empty && txReady) begin
          state_d = S_SEND;
        end
      end
      S_SEND: begin
        timer_d = TIMER_LOAD;
        state_d = S_WAIT_BUSY;
      end
      S_WAIT_BUSY: begin
        if (!txReady) begin
          state_d = S_WAIT_DONE;
        end else if (timer_q <= 16'd1) begin
          timer_d = '0;
          state_d = S_SEND;
        end else begin
          timer_d = timer_q - 16'd1;
        end
      end
      S_WAIT_DONE: begin
        if (txReady) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      state_q  <= S_IDLE;
      timer_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      state_q  <= state_d;
      timer_q  <= timer_d;
    end
  end

`ifdef SERIAL_TX_QUEUE_DROP_COUNT_EN
  logic [7:0] drop_q, drop_d;

  always_comb begin
    drop_d = drop_q;
    if (wrEn && full && (drop_q != 8'hFF)) begin
      drop_d = drop_q + 8'd1;
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      drop_q <= '0;
    end else begin
      drop_q <= drop_d;
    end
  end

  assign dropCount = drop_q;
`else
  assign dropCount = '0;
`endif

endmodule

// File: tb/tb_serial_tx_queue.sv
// Scoreboard bench for serial_tx_queue: a queue-based reference FIFO plus a transmitter model.
module tb_serial_tx_queue;
  localparam int ACK = 4;

  logic       CLK = 1'b0;
  logic       RESET = 1'b1;
  logic [7:0] wrData = 8'h00;
  logic       wrEn = 1'b0;
  logic       txReady = 1'b1;
  logic       full, empty, txSend, busy;
  logic [4:0] count;
  logic [7:0] txData, dropCount;

  serial_tx_queue #(.DEPTH_LOG2(4), .ACK_TIMEOUT(ACK)) dut (
    .CLK(CLK), .RESET(RESET), .wrData(wrData), .wrEn(wrEn),
    .full(full), .empty(empty), .count(count), .txData(txData),
    .txSend(txSend), .txReady(txReady), .busy(busy), .dropCount(dropCount)
  );

  always #5 CLK = ~CLK;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  logic [7:0] ref_q[$];
  int drops_exp = 0;
  int tx_mode = 0;  // 0 normal handshake, 1 hold txReady low, 2 hold txReady high (never ack)
  int fix_dly = 0;
  int fix_busy = 0;
  int tx_delay = 0;
  int tx_busy = 0;
  logic accept_pend = 1'b0;
  logic prev_send = 1'b0;
  int last_send = -1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic int drop_expected();
`ifdef SERIAL_TX_QUEUE_DROP_COUNT_EN
    return (drops_exp > 255) ? 255 : drops_exp;
`else
    return 0;
`endif
  endfunction

  always @(posedge CLK) cyc <= cyc + 1;

  // Reference FIFO: writes see the pre-edge occupancy, then an accepted byte leaves the head
  always @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      ref_q.delete();
      drops_exp = 0;
    end else begin
      if (wrEn) begin
        if (ref_q.size() < 16) ref_q.push_back(wrData);
        else drops_exp++;
      end
      if (accept_pend && ref_q.size() > 0) void'(ref_q.pop_front());
    end
  end

  // Transmitter model: after a strobe, wait 1..3 cycles, go busy (accepting the byte), then idle
  always @(negedge CLK) begin
    accept_pend = 1'b0;
    if (RESET) begin
      tx_delay = 0;
      tx_busy  = 0;
      txReady  = (tx_mode != 1);
    end else begin
      case (tx_mode)
        1: begin txReady = 1'b0; tx_delay = 0; tx_busy = 0; end
        2: begin txReady = 1'b1; tx_delay = 0; tx_busy = 0; end
        default: begin
          if (tx_busy > 0) begin
            tx_busy--;
            if (tx_busy == 0) txReady = 1'b1;
          end else if (tx_delay > 0) begin
            tx_delay--;
            if (tx_delay == 0) begin
              txReady = 1'b0;
              accept_pend = 1'b1;
              tx_busy = (fix_busy != 0) ? fix_busy : int'($urandom_range(1, 6));
            end
          end else begin
            txReady = 1'b1;
            if (txSend) tx_delay = (fix_dly != 0) ? fix_dly : int'($urandom_range(1, 3));
          end
        end
      endcase
    end
  end

  // Monitor: occupancy flags every cycle, head byte on every strobe, retry spacing when unacked
  always @(negedge CLK) begin
    if (!RESET) begin
      check("count", 32'(count), 32'(ref_q.size()));
      check("full", 32'(full), 32'(ref_q.size() == 16));
      check("empty", 32'(empty), 32'(ref_q.size() == 0));
      check("dropCount", 32'(dropCount), 32'(drop_expected()));
      if (txSend) begin
        check("single_cycle_send", 32'(prev_send), 32'd0);
        if (ref_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL send_data: got %0h expected no strobe (queue empty)", txData);
        end else begin
          check("send_data", 32'(txData), 32'(ref_q[0]));
        end
        if (tx_mode == 2) begin
          if (last_send >= 0) check("retry_gap", 32'(cyc - last_send), 32'(ACK + 1));
          last_send = cyc;
        end
      end
    end
    if (tx_mode != 2) last_send = -1;
    prev_send = txSend;
  end

  task automatic push(input logic [7:0] b);
    wrData = b;
    wrEn   = 1'b1;
    @(negedge CLK);
    wrEn   = 1'b0;
  endtask

  task automatic wait_idle(input string name, input int budget);
    bit done = 0;
    for (int i = 0; i < budget && !done; i++) begin
      @(negedge CLK);
      #1;
      if (ref_q.size() == 0 && !busy && txReady && tx_busy == 0 && tx_delay == 0) done = 1;
    end
    if (!done) begin
      tests++;
      fails++;
      $display("FAIL %s_timeout: got busy=%0b count=%0d expected idle within %0d cycles", name, busy, count, budget);
    end
  endtask

  initial begin
    bit done;
    bit seen_low;
    int sends;

    repeat (3) @(negedge CLK);
    #1;
    check("rst_full", 32'(full), 32'd0);
    check("rst_empty", 32'(empty), 32'd1);
    check("rst_count", 32'(count), 32'd0);
    check("rst_txSend", 32'(txSend), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_drop", 32'(dropCount), 32'd0);
    @(negedge CLK);
    RESET = 1'b0;
    @(negedge CLK);

    // Single byte: latency and busy release
    fix_dly = 1;
    fix_busy = 10;
    push(8'h41);
    #1;
    check("lat_n1_send", 32'(txSend), 32'd0);
    @(negedge CLK);
    #1;
    check("lat_n2_send", 32'(txSend), 32'd1);
    check("lat_n2_data", 32'(txData), 32'h41);
    done = 0;
    seen_low = 0;
    for (int i = 0; i < 40 && !done; i++) begin
      @(negedge CLK);
      #1;
      if (!txReady) seen_low = 1;
      else if (seen_low) begin
        check("busy_at_ready_rise", 32'(busy), 32'd1);
        check("count_after_pop", 32'(count), 32'd0);
        @(negedge CLK);
        #1;
        check("busy_fall", 32'(busy), 32'd0);
        done = 1;
      end
    end
    if (!done) begin
      tests++;
      fails++;
      $display("FAIL single_byte_timeout: got no txReady cycle expected one within 40 cycles");
    end
    wait_idle("single", 100);

    // Retry: transmitter never acknowledges
    fix_dly = 0;
    fix_busy = 0;
    tx_mode = 2;
    @(negedge CLK);
    push(8'h55);
    sends = 0;
    for (int i = 0; i < 60 && sends < 5; i++) begin
      @(negedge CLK);
      #1;
      if (txSend) sends++;
    end
    check("retry_sends", 32'(sends), 32'd5);
    tx_mode = 0;
    wait_idle("retry", 200);

    // Simultaneous write and pop with 5 queued
    tx_mode = 1;
    @(negedge CLK);
    for (int i = 0; i < 5; i++) push(8'(8'h10 + i));
    #1;
    check("simul_pre_count", 32'(count), 32'd5);
    fix_dly = 2;
    tx_mode = 0;
    done = 0;
    for (int i = 0; i < 40 && !done; i++) begin
      @(negedge CLK);
      #1;
      if (accept_pend) begin
        push(8'hA5);
        #1;
        check("simul_count", 32'(count), 32'd5);
        done = 1;
      end
    end
    if (!done) begin
      tests++;
      fails++;
      $display("FAIL simul_timeout: got no acknowledge expected one within 40 cycles");
    end
    fix_dly = 0;
    wait_idle("simul", 400);

    // Overflow with transmitter held busy
    tx_mode = 1;
    @(negedge CLK);
    for (int i = 0; i < 19; i++) push(8'(8'h60 + i));
    #1;
    check("ovf_full", 32'(full), 32'd1);
    check("ovf_count", 32'(count), 32'd16);
`ifdef SERIAL_TX_QUEUE_DROP_COUNT_EN
    check("ovf_drop", 32'(dropCount), 32'd3);
`else
    check("ovf_drop", 32'(dropCount), 32'd0);
`endif
    tx_mode = 0;
    wait_idle("ovf", 1000);

    // Order and wrap with a slow transmitter
    fix_dly = 3;
    fix_busy = 12;
    @(negedge CLK);
    for (int i = 0; i < 20; i++) push(8'(i));
    wait_idle("wrap", 2000);
    fix_dly = 0;
    fix_busy = 0;

    // Reset while waiting for the acknowledge
    tx_mode = 2;
    @(negedge CLK);
    push(8'h77);
    done = 0;
    for (int i = 0; i < 10 && !done; i++) begin
      @(negedge CLK);
      #1;
      if (txSend) done = 1;
    end
    check("rst_mid_sent", 32'(done), 32'd1);
    @(negedge CLK);
    #1;
    check("rst_mid_waiting", 32'(busy), 32'd1);
    #2;
    RESET = 1'b1;
    #1;
    check("rst_mid_txSend", 32'(txSend), 32'd0);
    check("rst_mid_empty", 32'(empty), 32'd1);
    check("rst_mid_busy", 32'(busy), 32'd0);
    check("rst_mid_drop", 32'(dropCount), 32'd0);
    tx_mode = 0;
    @(negedge CLK);
    @(negedge CLK);
    RESET = 1'b0;
    @(negedge CLK);
    push(8'h78);
    wait_idle("post_reset", 100);

    // Randomized traffic
    for (int i = 0; i < 1500; i++) begin
      @(negedge CLK);
      wrEn   = ($urandom_range(0, 2) == 0);
      wrData = 8'($urandom);
    end
    @(negedge CLK);
    wrEn = 1'b0;
    wait_idle("random", 4000);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
